// File: rtl/computer_pkg.sv
// Shared types and RAM geometry for the 8-bit computer: loader FSM states and
// the program RAM width constants used by the loader, RAM and CPU.
package computer_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    WRITE    = 2'd2,
    RELEASE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Program RAM write port: single-cycle strobe with registered address and data.
// The loader drives it through master; the RAM consumes it through slave.
interface ram_loader_if
  import computer_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  modport master (output ram_we, ram_addr, ram_wdata);
  modport slave  (input  ram_we, ram_addr, ram_wdata);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
// Latency: 2 clk. No backpressure; reset value is a parameter.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ram_loader.sv
// Manual program-RAM writer: debounced push button -> one registered RAM write strobe.
// Latency: strobe in the cycle after E2+DEBOUNCE_CYCLES; no backpressure (the RAM always accepts).
module ram_loader
  import computer_pkg::*;
#(
  parameter int ADDR_W          = RAM_ADDR_W,
  parameter int DATA_W          = RAM_DATA_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              autoinc,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              key_write_n,
  ram_loader_if.master      ram,
  output logic              cpu_hold,
  output logic              busy,
  output logic [ADDR_W-1:0] next_addr,
  output logic [7:0]        wr_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic key_s, prog_s;

  sync_2ff #(.RST_VAL(1'b1)) u_key_sync (.clk(clk), .rst_n(rst_n), .d(key_write_n), .q(key_s));
  sync_2ff #(.RST_VAL(1'b0)) u_prog_sync (.clk(clk), .rst_n(rst_n), .d(prog_mode), .q(prog_s));

  loader_state_t     state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              ram_we_d, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q;
  logic [ADDR_W-1:0] next_addr_d, next_addr_q;
  logic [7:0]        wr_count_d, wr_count_q;
  logic              prog_s_d, prog_s_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    next_addr_d = next_addr_q;
    wr_count_d  = wr_count_q;
    prog_s_d    = prog_s;

    case (state_q)
      IDLE: begin
        if (prog_s && !key_s) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (!prog_s || key_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = WRITE;
          ram_addr_d  = autoinc ? next_addr_q : sw_addr;
          ram_wdata_d = sw_data;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The write is committed once here; losing prog_s cannot cancel it.
      WRITE: begin
        state_d    = RELEASE;
        cnt_d      = '0;
        wr_count_d = (wr_count_q == 8'hFF) ? wr_count_q : wr_count_q + 8'd1;
        if (autoinc) next_addr_d = next_addr_q + ADDR_W'(1);
      end
      RELEASE: begin
        if (!prog_s) begin
          state_d = IDLE;
        end else if (!key_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (prog_s && !prog_s_q) next_addr_d = '0;
    ram_we_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      next_addr_q <= '0;
      wr_count_q  <= '0;
      prog_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      next_addr_q <= next_addr_d;
      wr_count_q  <= wr_count_d;
      prog_s_q    <= prog_s_d;
    end
  end

  assign ram.ram_we    = ram_we_q;
  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_wdata = ram_wdata_q;
  assign busy          = (state_q != IDLE);
  assign cpu_hold      = prog_s | busy;
  assign next_addr     = next_addr_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: randomized button presses against a press-level reference
// model; expected writes go to a scoreboard queue popped by a write-port monitor.
module tb_ram_loader;

  localparam int DBC = 4;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_mode = 1'b0;
  logic       autoinc = 1'b0;
  logic [3:0] sw_addr = 4'h0;
  logic [7:0] sw_data = 8'h00;
  logic       key_write_n = 1'b1;
  logic       cpu_hold, busy;
  logic [3:0] next_addr;
  logic [7:0] wr_count;

  ram_loader_if ram_if ();

  ram_loader #(
    .ADDR_W(4), .DATA_W(8), .DEBOUNCE_CYCLES(DBC), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .autoinc(autoinc),
    .sw_addr(sw_addr), .sw_data(sw_data), .key_write_n(key_write_n),
    .ram(ram_if.master), .cpu_hold(cpu_hold), .busy(busy),
    .next_addr(next_addr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic [3:0] mnext = 4'h0;
  int   mcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobed cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_if.ram_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, expected no write",
                 ram_if.ram_addr, ram_if.ram_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ram_if.ram_addr !== e.addr || ram_if.ram_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write_content: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   ram_if.ram_addr, ram_if.ram_wdata, e.addr, e.data);
        end
      end
    end
  end

  // A press writes only if the button is seen low for 1 entry cycle plus DBC debounce cycles.
  task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = autoinc ? mnext : a;
    e.data = d;
    exp_q.push_back(e);
    if (autoinc) mnext = mnext + 4'h1;
    if (mcount != 255) mcount++;
  endtask

  task automatic press(input int len, input logic [3:0] a, input logic [7:0] d);
    sw_addr = a;
    sw_data = d;
    if (len >= DBC + 1) expect_write(a, d);
    key_write_n = 1'b0;
    repeat (len) @(negedge clk);
    key_write_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic set_mode(input logic ai);
    prog_mode = 1'b0;
    repeat (4) @(negedge clk);
    autoinc   = ai;
    prog_mode = 1'b1;
    mnext     = 4'h0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, pulses;
    logic [3:0] ra;
    logic [7:0] rd;

    repeat (3) @(negedge clk);
    check("rst_ram_we", ram_if.ram_we, 0);
    check("rst_ram_addr", ram_if.ram_addr, 0);
    check("rst_ram_wdata", ram_if.ram_wdata, 0);
    check("rst_next_addr", next_addr, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_mode(1'b0);
    check("prog_cpu_hold", cpu_hold, 1);

    // Glitch: two low samples never reach WRITE.
    press(2, 4'h3, 8'hA5);
    check("glitch_wr_count", wr_count, 0);
    check("glitch_busy", busy, 0);

    // Single held press: strobe lands after E6, exactly once.
    sw_addr = 4'h3;
    sw_data = 8'hA5;
    expect_write(4'h3, 8'hA5);
    key_write_n = 1'b0;
    first  = -1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_if.ram_we === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    key_write_n = 1'b1;
    repeat (12) @(negedge clk);
    check("latency_first_we", first, 6);
    check("single_pulse_count", pulses, 1);
    check("single_wr_count", wr_count, 1);

    // Mode drop during DEBOUNCE aborts the write.
    key_write_n = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 2) prog_mode = 1'b0;
      if (i == 5) begin
        check("abort_busy", busy, 0);
        check("abort_cpu_hold", cpu_hold, 0);
      end
    end
    key_write_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_wr_count", wr_count, 1);

    // Mode drop landing in WRITE: the strobe still completes.
    set_mode(1'b0);
    sw_addr = 4'h7;
    sw_data = 8'h3C;
    expect_write(4'h7, 8'h3C);
    key_write_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 4) prog_mode = 1'b0;
    end
    key_write_n = 1'b1;
    repeat (6) @(negedge clk);
    check("write_abort_wr_count", wr_count, 2);
    check("write_abort_busy", busy, 0);

    // Auto-increment across the 15 -> 0 wrap.
    set_mode(1'b1);
    for (int i = 0; i < 17; i++) press($urandom_range(5, 10), 4'($urandom), 8'(i));
    check("wrap_next_addr", next_addr, 1);
    check("wrap_wr_count", wr_count, 8'(mcount));

    // Random blocks of presses, including glitches and the debounce boundary.
    for (int b = 0; b < 6; b++) begin
      set_mode(1'($urandom));
      for (int p = 0; p < 8; p++) begin
        ra = 4'($urandom);
        rd = 8'($urandom);
        press($urandom_range(1, 12), ra, rd);
      end
      check("rand_next_addr", next_addr, mnext);
      check("rand_wr_count", wr_count, 8'(mcount));
    end

    // Async reset while in RELEASE with the key still held.
    set_mode(1'b1);
    sw_data = 8'h5A;
    expect_write(4'h0, 8'h5A);
    key_write_n = 1'b0;
    repeat (10) @(negedge clk);
    key_write_n = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ram_we", ram_if.ram_we, 0);
    check("midrst_ram_addr", ram_if.ram_addr, 0);
    check("midrst_ram_wdata", ram_if.ram_wdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cpu_hold", cpu_hold, 0);
    check("midrst_next_addr", next_addr, 0);
    check("midrst_wr_count", wr_count, 0);
    #1 rst_n = 1'b1;
    mnext  = 4'h0;
    mcount = 0;
    repeat (12) @(negedge clk);
    check("postrst_wr_count", wr_count, 0);
    check("postrst_next_addr", next_addr, 0);
    check("postrst_busy", busy, 0);

    // Saturation of the write counter.
    set_mode(1'b0);
    while (mcount < 255) press(5, 4'h9, 8'($urandom));
    for (int i = 0; i < 3; i++) press(6, 4'h9, 8'($urandom));
    check("sat_wr_count", wr_count, 8'hFF);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
